rtsnoc_to_wishbone_master: RTL and testbench

RTSNOC_TO_WISHBONE_MASTER -- requirements
Module: rtsnoc_to_wishbone_master

---
 rtl/rtsnoc_to_wishbone_master.sv | 153 +++++++++++++++
 tb/tb_rtsnoc_to_wishbone_master.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtsnoc_to_wishbone_master.sv
// Bridges RTSNoC command flits to a single Wishbone master port.
// A WRITE command is followed by one data flit; a READ command is answered
// with one reply flit addressed back to the requester.
module rtsnoc_to_wishbone_master #(
    parameter int WB_ADDR_WIDTH     = 6,
    parameter int WB_NOC_DATA_WIDTH = 32,
    parameter int NOC_LOCAL_ADR     = 0,
    parameter int NOC_X             = 0,
    parameter int NOC_Y             = 0,
    parameter int SOC_SIZE_X        = 1,
    parameter int SOC_SIZE_Y        = 1,
    parameter int WB_TIMEOUT        = 255,
    localparam int NOC_BUS_SIZE     = WB_NOC_DATA_WIDTH + 2*SOC_SIZE_X + 2*SOC_SIZE_Y + 6
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NOC_BUS_SIZE-1:0]      noc_dout_i,
    input  logic                         noc_nd_i,
    output logic                         noc_rd_o,
    output logic [NOC_BUS_SIZE-1:0]      noc_din_o,
    output logic                         noc_wr_o,
    input  logic                         noc_wait_i,
    output logic                         wb_cyc_o,
    output logic                         wb_stb_o,
    output logic                         wb_we_o,
    output logic [WB_ADDR_WIDTH-1:0]     wb_adr_o,
    output logic [3:0]                   wb_sel_o,
    output logic [WB_NOC_DATA_WIDTH-1:0] wb_dat_o,
    input  logic [WB_NOC_DATA_WIDTH-1:0] wb_dat_i,
    input  logic                         wb_ack_i
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] GAP        = 3'd1;
    localparam logic [2:0] WAIT_WDATA = 3'd2;
    localparam logic [2:0] WB_WR      = 3'd3;
    localparam logic [2:0] WB_RD      = 3'd4;
    localparam logic [2:0] TX         = 3'd5;
    localparam logic [2:0] TX_WAIT    = 3'd6;

    localparam logic [2:0] OP_WRITE = 3'd0;
    localparam logic [2:0] OP_READ  = 3'd1;

    // Flit field offsets, LSB first: data, local_dst, Y_dst, X_dst, local_orig, Y_orig, X_orig
    localparam int LDST_LSB = WB_NOC_DATA_WIDTH;
    localparam int YDST_LSB = LDST_LSB + 3;
    localparam int XDST_LSB = YDST_LSB + SOC_SIZE_Y;
    localparam int LORG_LSB = XDST_LSB + SOC_SIZE_X;
    localparam int YORG_LSB = LORG_LSB + 3;
    localparam int XORG_LSB = YORG_LSB + SOC_SIZE_Y;

    localparam logic [SOC_SIZE_X-1:0] OWN_X = SOC_SIZE_X'(NOC_X);
    localparam logic [SOC_SIZE_Y-1:0] OWN_Y = SOC_SIZE_Y'(NOC_Y);
    localparam logic [2:0]            OWN_L = 3'(NOC_LOCAL_ADR);
    localparam logic [7:0]            TIMEOUT_LAST = 8'(WB_TIMEOUT - 1);

    logic [2:0]            state;
    logic [2:0]            after_gap;
    logic [7:0]            timer;
    logic [SOC_SIZE_X-1:0] req_x;
    logic [SOC_SIZE_Y-1:0] req_y;
    logic [2:0]            req_l;

    // The destination header of incoming flits is not needed: this node is the destination.
    logic unused_dst;
    assign unused_dst = ^noc_dout_i[XDST_LSB+SOC_SIZE_X-1:LDST_LSB];

    assign wb_stb_o = wb_cyc_o;
    assign wb_sel_o = 4'hF;

    // Transaction sequencer: pop/decode flits, run the bus cycle, send the reply.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            after_gap <= IDLE;
            timer     <= '0;
            req_x     <= '0;
            req_y     <= '0;
            req_l     <= '0;
            wb_cyc_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            noc_din_o <= '0;
            noc_rd_o  <= 1'b0;
            noc_wr_o  <= 1'b0;
        end else begin
            noc_rd_o <= 1'b0;
            noc_wr_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (noc_nd_i) begin
                        noc_rd_o <= 1'b1;
                        state    <= GAP;
                        case (noc_dout_i[31:29])
                            OP_WRITE: begin
                                wb_adr_o  <= noc_dout_i[WB_ADDR_WIDTH-1:0];
                                after_gap <= WAIT_WDATA;
                            end
                            OP_READ: begin
                                wb_adr_o  <= noc_dout_i[WB_ADDR_WIDTH-1:0];
                                req_x     <= noc_dout_i[XORG_LSB +: SOC_SIZE_X];
                                req_y     <= noc_dout_i[YORG_LSB +: SOC_SIZE_Y];
                                req_l     <= noc_dout_i[LORG_LSB +: 3];
                                after_gap <= WB_RD;
                            end
                            default: after_gap <= IDLE;
                        endcase
                    end
                end
                WAIT_WDATA: begin
                    if (noc_nd_i) begin
                        noc_rd_o  <= 1'b1;
                        wb_dat_o  <= noc_dout_i[WB_NOC_DATA_WIDTH-1:0];
                        after_gap <= WB_WR;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    state <= after_gap;
                    if (after_gap == WB_WR || after_gap == WB_RD) begin
                        wb_cyc_o <= 1'b1;
                        wb_we_o  <= (after_gap == WB_WR);
                        timer    <= '0;
                    end
                end
                WB_WR, WB_RD: begin
                    if (wb_ack_i || timer == TIMEOUT_LAST) begin
                        wb_cyc_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        if (state == WB_RD) begin
                            // Read data is captured on the ack edge; a timeout replies with zero.
                            noc_din_o <= {OWN_X, OWN_Y, OWN_L, req_x, req_y, req_l,
                                          wb_ack_i ? wb_dat_i : {WB_NOC_DATA_WIDTH{1'b0}}};
                            noc_wr_o  <= 1'b1;
                            state     <= TX;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                TX: state <= TX_WAIT;
                TX_WAIT: begin
                    if (!noc_wait_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtsnoc_to_wishbone_master.sv
// Self-checking bench for rtsnoc_to_wishbone_master: NoC source FIFO model,
// Wishbone slave model and scoreboard queues of expected bus cycles / replies.
module tb_rtsnoc_to_wishbone_master;

    localparam int FW = 42;

    typedef struct {
        logic        we;
        logic [5:0]  adr;
        logic [31:0] dat;
        int          len;
    } bus_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [FW-1:0] noc_dout_i;
    logic          noc_nd_i;
    logic          noc_rd_o;
    logic [FW-1:0] noc_din_o;
    logic          noc_wr_o;
    logic          noc_wait_i;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic [5:0]    wb_adr_o;
    logic [3:0]    wb_sel_o;
    logic [31:0]   wb_dat_o;
    logic [31:0]   wb_dat_i;
    logic          wb_ack_i;

    int checks = 0;
    int passed = 0;

    logic [FW-1:0] src_q[$];
    bus_t          exp_bus[$];
    bus_t          obs_bus[$];
    logic [FW-1:0] exp_reply[$];
    logic [FW-1:0] obs_reply[$];

    int unsigned pops = 0;
    int          pop_empty = 0;
    int          proto_err = 0;
    int          rd_wide = 0;
    int          wr_wide = 0;
    int          ack_delay = 1;
    int          ack_cnt = 0;
    int          cur_len = 0;
    bus_t        cur;
    logic        prev_rd = 1'b0;
    logic        prev_wr = 1'b0;

    rtsnoc_to_wishbone_master #(
        .WB_ADDR_WIDTH(6), .WB_NOC_DATA_WIDTH(32), .NOC_LOCAL_ADR(5),
        .NOC_X(1), .NOC_Y(1), .SOC_SIZE_X(1), .SOC_SIZE_Y(1), .WB_TIMEOUT(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .noc_dout_i(noc_dout_i), .noc_nd_i(noc_nd_i), .noc_rd_o(noc_rd_o),
        .noc_din_o(noc_din_o), .noc_wr_o(noc_wr_o), .noc_wait_i(noc_wait_i),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    always #5 clk_i = ~clk_i;

    // Command flit from (ox,oy,ol) to an arbitrary destination the bridge must ignore.
    function automatic logic [FW-1:0] cmd_flit(input logic ox, input logic oy,
                                               input logic [2:0] ol, input logic [31:0] d);
        return {ox, oy, ol, 1'b0, 1'b0, 3'd7, d};
    endfunction

    // Reply expected from node (1,1,5) back to the requester.
    function automatic logic [FW-1:0] reply_flit(input logic dx, input logic dy,
                                                 input logic [2:0] dl, input logic [31:0] d);
        return {1'b1, 1'b1, 3'd5, dx, dy, dl, d};
    endfunction

    // NoC source, Wishbone slave and output monitor, all evaluated mid-cycle.
    always @(negedge clk_i) begin
        if (wb_cyc_o) begin
            if (cur_len == 0) begin
                cur.we = wb_we_o; cur.adr = wb_adr_o; cur.dat = wb_dat_o;
            end
            cur_len++;
            if (wb_stb_o !== 1'b1 || wb_sel_o !== 4'hF || wb_we_o !== cur.we || wb_adr_o !== cur.adr)
                proto_err++;
        end else if (cur_len != 0) begin
            cur.len = cur_len;
            obs_bus.push_back(cur);
            cur_len = 0;
        end
        if (!wb_cyc_o) begin
            wb_ack_i = 1'b0; ack_cnt = 0;
        end else if (!wb_ack_i) begin
            ack_cnt++;
            if (ack_cnt == ack_delay) wb_ack_i = 1'b1;
        end
        if (noc_wr_o) obs_reply.push_back(noc_din_o);
        if (noc_wr_o && prev_wr) wr_wide++;
        if (noc_rd_o && prev_rd) rd_wide++;
        prev_wr = noc_wr_o;
        prev_rd = noc_rd_o;
        if (noc_rd_o) begin
            pops++;
            if (src_q.size() > 0) void'(src_q.pop_front());
            else pop_empty++;
        end
        noc_nd_i   = (src_q.size() > 0);
        noc_dout_i = (src_q.size() > 0) ? src_q[0] : '0;
    end

    task automatic wait_bus(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (obs_bus.size() >= n) begin ok = 1'b1; break; end
            @(negedge clk_i);
        end
    endtask

    task automatic wait_reply(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (obs_reply.size() >= 1) begin ok = 1'b1; break; end
            @(negedge clk_i);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) $display("FAIL reset_bus_ctl: got %b need 000", {wb_cyc_o, wb_stb_o, wb_we_o}); else passed++;
        checks++; if ({noc_rd_o, noc_wr_o} !== 2'b00) $display("FAIL reset_noc_ctl: got %b need 00", {noc_rd_o, noc_wr_o}); else passed++;
        checks++; if (wb_adr_o !== 6'h0 || wb_dat_o !== 32'h0) $display("FAIL reset_adr_dat: got adr=%h dat=%h need 0/0", wb_adr_o, wb_dat_o); else passed++;
        checks++; if (noc_din_o !== '0) $display("FAIL reset_din: got %h need 0", noc_din_o); else passed++;
        checks++; if (wb_sel_o !== 4'hF) $display("FAIL reset_sel: got %h need f", wb_sel_o); else passed++;
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_write();
        bus_t ex, ob; bit ok; int unsigned p0;
        p0 = pops; ack_delay = 3;
        exp_bus.push_back('{we:1'b1, adr:6'h05, dat:32'hCAFEF00D, len:3});
        src_q.push_back(cmd_flit(1'b0, 1'b1, 3'd4, 32'h0000_0005));
        src_q.push_back(cmd_flit(1'b0, 1'b1, 3'd4, 32'hCAFE_F00D));
        wait_bus(1, ok);
        checks++; if (!ok) $display("FAIL write_seen: got no bus cycle need one"); else passed++;
        if (ok) begin
            ob = obs_bus.pop_front(); ex = exp_bus.pop_front();
            checks++; if (ob.we !== ex.we || ob.adr !== ex.adr) $display("FAIL write_we_adr: got we=%b adr=%h need we=%b adr=%h", ob.we, ob.adr, ex.we, ex.adr); else passed++;
            checks++; if (ob.dat !== ex.dat) $display("FAIL write_dat: got %h need %h", ob.dat, ex.dat); else passed++;
            checks++; if (ob.len != ex.len) $display("FAIL write_len: got %0d need %0d", ob.len, ex.len); else passed++;
        end
        repeat (6) @(negedge clk_i);
        checks++; if (pops - p0 != 2) $display("FAIL write_pops: got %0d need 2", pops - p0); else passed++;
        checks++; if (obs_reply.size() != 0) $display("FAIL write_no_reply: got %0d replies need 0", obs_reply.size()); else passed++;
        exp_bus.delete(); obs_reply.delete();
    endtask

    task automatic test_read();
        bus_t ob; bit ok; logic [FW-1:0] er;
        ack_delay = 2; wb_dat_i = 32'h1234_5678; noc_wait_i = 1'b0;
        exp_bus.push_back('{we:1'b0, adr:6'h12, dat:32'h0, len:2});
        exp_reply.push_back(reply_flit(1'b1, 1'b0, 3'd2, 32'h1234_5678));
        src_q.push_back(cmd_flit(1'b1, 1'b0, 3'd2, 32'h2000_0012));
        wait_reply(ok);
        checks++; if (!ok) $display("FAIL read_reply_seen: got no reply need one"); else passed++;
        if (ok) begin
            er = exp_reply.pop_front();
            checks++; if (obs_reply[0] !== er) $display("FAIL read_reply: got %h need %h", obs_reply[0], er); else passed++;
        end
        if (obs_bus.size() > 0) begin
            ob = obs_bus.pop_front();
            checks++; if (ob.we !== exp_bus[0].we || ob.adr !== exp_bus[0].adr || ob.len != exp_bus[0].len)
                $display("FAIL read_bus: got we=%b adr=%h len=%0d need we=0 adr=12 len=2", ob.we, ob.adr, ob.len); else passed++;
        end
        repeat (4) @(negedge clk_i);
        checks++; if (obs_reply.size() != 1) $display("FAIL read_reply_count: got %0d need 1", obs_reply.size()); else passed++;
        exp_bus.delete(); exp_reply.delete(); obs_reply.delete(); obs_bus.delete();
    endtask

    task automatic test_back_pressure();
        bus_t ob; bit ok; int unsigned p0; logic [FW-1:0] er;
        p0 = pops; ack_delay = 1; wb_dat_i = 32'hDEAD_BEEF; noc_wait_i = 1'b1;
        er = reply_flit(1'b0, 1'b0, 3'd1, 32'hDEAD_BEEF);
        exp_bus.push_back('{we:1'b1, adr:6'h03, dat:32'h0102_0304, len:1});
        src_q.push_back(cmd_flit(1'b0, 1'b0, 3'd1, 32'h2000_0021));
        src_q.push_back(cmd_flit(1'b1, 1'b1, 3'd3, 32'h0000_0003));
        src_q.push_back(cmd_flit(1'b1, 1'b1, 3'd3, 32'h0102_0304));
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (noc_wr_o === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk_i);
        end
        checks++; if (!ok) $display("FAIL bp_reply_seen: got no reply pulse need one"); else passed++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            checks++; if (noc_din_o !== er || noc_rd_o !== 1'b0)
                $display("FAIL bp_hold_%0d: got din=%h rd=%b need din=%h rd=0", i, noc_din_o, noc_rd_o, er); else passed++;
        end
        checks++; if (pops - p0 != 1) $display("FAIL bp_no_pop: got %0d pops need 1", pops - p0); else passed++;
        noc_wait_i = 1'b0;
        obs_bus.delete();
        wait_bus(1, ok);
        checks++; if (!ok) $display("FAIL bp_write_seen: got no bus cycle need one"); else passed++;
        if (ok) begin
            ob = obs_bus.pop_front();
            checks++; if (ob.we !== 1'b1 || ob.adr !== exp_bus[0].adr || ob.dat !== exp_bus[0].dat)
                $display("FAIL bp_write: got we=%b adr=%h dat=%h need we=1 adr=03 dat=01020304", ob.we, ob.adr, ob.dat); else passed++;
        end
        repeat (4) @(negedge clk_i);
        checks++; if (pops - p0 != 3) $display("FAIL bp_total_pops: got %0d need 3", pops - p0); else passed++;
        exp_bus.delete(); obs_reply.delete(); obs_bus.delete();
    endtask

    task automatic test_timeout();
        bus_t ob; bit ok; logic [FW-1:0] er;
        ack_delay = -1; wb_dat_i = 32'hFFFF_FFFF;
        er = reply_flit(1'b0, 1'b1, 3'd3, 32'h0);
        src_q.push_back(cmd_flit(1'b0, 1'b1, 3'd3, 32'h2000_0007));
        wait_reply(ok);
        checks++; if (!ok) $display("FAIL timeout_reply_seen: got no reply need one"); else passed++;
        if (ok) begin
            checks++; if (obs_reply[0] !== er) $display("FAIL timeout_reply: got %h need %h", obs_reply[0], er); else passed++;
        end
        if (obs_bus.size() > 0) begin
            ob = obs_bus.pop_front();
            checks++; if (ob.len != 8 || ob.adr !== 6'h07) $display("FAIL timeout_len: got len=%0d adr=%h need len=8 adr=07", ob.len, ob.adr); else passed++;
        end
        repeat (4) @(negedge clk_i);
        obs_reply.delete(); obs_bus.delete();
        ack_delay = 1;
    endtask

    task automatic test_bad_opcode();
        bus_t ob; bit ok; int unsigned p0;
        p0 = pops; ack_delay = 1;
        src_q.push_back(cmd_flit(1'b1, 1'b0, 3'd6, 32'h4000_0000));
        src_q.push_back(cmd_flit(1'b1, 1'b0, 3'd6, 32'h0000_0009));
        src_q.push_back(cmd_flit(1'b1, 1'b0, 3'd6, 32'h0BAD_BEEF));
        wait_bus(1, ok);
        repeat (8) @(negedge clk_i);
        checks++; if (obs_bus.size() != 1) $display("FAIL badop_bus_count: got %0d need 1", obs_bus.size()); else passed++;
        if (obs_bus.size() > 0) begin
            ob = obs_bus.pop_front();
            checks++; if (ob.we !== 1'b1 || ob.adr !== 6'h09 || ob.dat !== 32'h0BAD_BEEF)
                $display("FAIL badop_write: got we=%b adr=%h dat=%h need we=1 adr=09 dat=0badbeef", ob.we, ob.adr, ob.dat); else passed++;
        end
        checks++; if (pops - p0 != 3) $display("FAIL badop_pops: got %0d need 3", pops - p0); else passed++;
        checks++; if (obs_reply.size() != 0) $display("FAIL badop_no_reply: got %0d need 0", obs_reply.size()); else passed++;
        obs_bus.delete(); obs_reply.delete();
    endtask

    task automatic test_reset_mid();
        bus_t ob; bit ok; int unsigned p0; logic [FW-1:0] er;
        p0 = pops; ack_delay = 1; wb_dat_i = 32'hA5A5_5A5A;
        src_q.push_back(cmd_flit(1'b0, 1'b0, 3'd0, 32'h0000_000A));
        for (int i = 0; i < 100 && pops == p0; i++) @(negedge clk_i);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        checks++; if ({wb_cyc_o, wb_we_o, noc_rd_o, noc_wr_o} !== 4'b0000) $display("FAIL rstmid_ctl: got %b need 0000", {wb_cyc_o, wb_we_o, noc_rd_o, noc_wr_o}); else passed++;
        checks++; if (wb_adr_o !== 6'h0 || wb_dat_o !== 32'h0 || noc_din_o !== '0)
            $display("FAIL rstmid_regs: got adr=%h dat=%h din=%h need 0", wb_adr_o, wb_dat_o, noc_din_o); else passed++;
        rst_i = 1'b0;
        @(negedge clk_i);
        er = reply_flit(1'b1, 1'b1, 3'd1, 32'hA5A5_5A5A);
        src_q.push_back(cmd_flit(1'b1, 1'b1, 3'd1, 32'h2000_002C));
        wait_reply(ok);
        checks++; if (!ok) $display("FAIL rstmid_reply_seen: got no reply need one"); else passed++;
        if (ok) begin
            checks++; if (obs_reply[0] !== er) $display("FAIL rstmid_reply: got %h need %h", obs_reply[0], er); else passed++;
        end
        checks++; if (obs_bus.size() != 1) $display("FAIL rstmid_bus_count: got %0d need 1", obs_bus.size()); else passed++;
        if (obs_bus.size() > 0) begin
            ob = obs_bus.pop_front();
            checks++; if (ob.we !== 1'b0 || ob.adr !== 6'h2C) $display("FAIL rstmid_bus: got we=%b adr=%h need we=0 adr=2c", ob.we, ob.adr); else passed++;
        end
        repeat (4) @(negedge clk_i);
        obs_reply.delete(); obs_bus.delete();
    endtask

    task automatic test_protocol();
        checks++; if (proto_err != 0) $display("FAIL proto_bus: got %0d violations need 0", proto_err); else passed++;
        checks++; if (pop_empty != 0) $display("FAIL proto_pop_empty: got %0d need 0", pop_empty); else passed++;
        checks++; if (rd_wide != 0 || wr_wide != 0) $display("FAIL proto_pulse: got rd=%0d wr=%0d need 0/0", rd_wide, wr_wide); else passed++;
    endtask

    initial begin
        rst_i = 1'b1; noc_dout_i = '0; noc_nd_i = 1'b0; noc_wait_i = 1'b0;
        wb_dat_i = '0; wb_ack_i = 1'b0;
        @(negedge clk_i);
        test_reset();
        test_write();
        test_read();
        test_back_pressure();
        test_timeout();
        test_bad_opcode();
        test_reset_mid();
        test_protocol();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
